// File: rtl/detector.sv
// detector: pulse-interval symbol decoder; define DETECTOR_SYNC_EN to add a 2-flop input synchronizer
module detector #(
  parameter int CNT_W   = 19,
  parameter int THRESH  = 1024,
  parameter int TIMEOUT = 500000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trigger,
  output logic [CNT_W-1:0] cnt,
  output logic [3:0]       B,
  output logic [4:0]       bits
);
  localparam logic [CNT_W-1:0] THR_M1 = CNT_W'(THRESH - 1);
  localparam logic [CNT_W-1:0] TO_M1  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TO     = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t           state_q;
  logic             trig_s, trig_q, rise;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       b_q;
  logic [4:0]       bits_q;
`ifdef DETECTOR_SYNC_EN
  logic [1:0] sync_q;
  // two-flop synchronizer for an asynchronous trigger line
  always_ff @(posedge clk or negedge rst)
    if (!rst) sync_q <= '0;
    else sync_q <= {sync_q[0], trigger};
  assign trig_s = sync_q[1];
`else
  assign trig_s = trigger;
`endif
  assign rise = trig_s & ~trig_q;
  // frame FSM: measure edge intervals, shift symbols in, end the frame after silence
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      trig_q  <= 1'b0;
      cnt_q   <= '0;
      b_q     <= '0;
      bits_q  <= '0;
    end else begin
      trig_q <= trig_s;
      if (state_q == IDLE) begin
        if (rise) begin
          state_q <= ACTIVE;
          cnt_q   <= '0;
          b_q     <= '0;
          bits_q  <= '0;
        end
      end else if (rise) begin
        cnt_q  <= '0;
        b_q    <= {b_q[2:0], cnt_q >= THR_M1};
        bits_q <= (bits_q == 5'd31) ? 5'd31 : bits_q + 5'd1;
      end else if (cnt_q == TO_M1) begin
        cnt_q   <= TO;
        state_q <= IDLE;
      end else begin
        cnt_q <= cnt_q + ONE;
      end
    end
  assign cnt  = cnt_q;
  assign B    = b_q;
  assign bits = bits_q;
endmodule

// File: tb/tb_detector.sv
// tb_detector: scoreboard bench for the pulse-interval decoder (reduced TIMEOUT for run length)
module tb_detector;
  localparam int CNT_W = 19, THRESH = 1024, TIMEOUT = 5000;
`ifdef DETECTOR_SYNC_EN
  localparam int OFF = 2;
`else
  localparam int OFF = 0;
`endif
  logic clk = 1'b0, rst = 1'b0, trigger = 1'b0;
  logic [CNT_W-1:0] cnt;
  logic [3:0] B;
  logic [4:0] bits;
  detector #(.CNT_W(CNT_W), .THRESH(THRESH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .trigger(trigger), .cnt(cnt), .B(B), .bits(bits));
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int checks = 0, errors = 0;
  typedef struct packed {logic [CNT_W-1:0] c; logic [3:0] b; logic [4:0] n;} exp_t;
  exp_t sb[$];
  bit m_act = 1'b0;
  int m_le = 0, le = 0;
  logic [3:0] m_b = '0;
  logic [4:0] m_n = '0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic at_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic fire(input string tag, input int gap, input int hold);
    int e;
    exp_t x;
    while (cyc + 1 < le + gap) @(negedge clk);
    trigger = 1'b1;
    e = cyc + 1;
    if (!m_act || e - m_le > TIMEOUT) begin
      m_b = '0;
      m_n = '0;
      m_act = 1'b1;
    end else begin
      m_b = {m_b[2:0], (e - m_le) >= THRESH};
      m_n = (m_n == 5'd31) ? 5'd31 : m_n + 5'd1;
    end
    m_le = e;
    le = e;
    x.c = '0;
    x.b = m_b;
    x.n = m_n;
    sb.push_back(x);
    at_cyc(e + OFF);
    x = sb.pop_front();
    check({tag, "_cnt"}, 32'(cnt), 32'(x.c));
    check({tag, "_B"}, 32'(B), 32'(x.b));
    check({tag, "_bits"}, 32'(bits), 32'(x.n));
    while (cyc + 1 < e + hold) @(negedge clk);
    trigger = 1'b0;
  endtask
  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b0;
    m_act = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    le = cyc;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(negedge clk);
    check("rst_cnt", 32'(cnt), 0);
    check("rst_B", 32'(B), 0);
    check("rst_bits", 32'(bits), 0);
    rst = 1'b1;
    le = cyc;
    fire("s1_start", 2, 10);
    at_cyc(le + OFF + 100);
    check("s1_counting", 32'(cnt), 100);
    fire("s1_e2", 510, 10);
    fire("s1_e3", 510, 10);
    check("s1_bits2", 32'(bits), 2);
    at_cyc(le + OFF + TIMEOUT - 1);
    check("to_pre_cnt", 32'(cnt), TIMEOUT - 1);
    at_cyc(le + OFF + TIMEOUT);
    check("to_cnt", 32'(cnt), TIMEOUT);
    at_cyc(le + OFF + TIMEOUT + 1000);
    check("to_hold_cnt", 32'(cnt), TIMEOUT);
    check("to_hold_B", 32'(B), 0);
    check("to_hold_bits", 32'(bits), 2);
    fire("s2_restart", TIMEOUT + 1020, 10);
    fire("s3_2000", 2000, 10);
    fire("s3_500", 500, 10);
    fire("s3_1024", 1024, 10);
    fire("s3_1023", 1023, 10);
    check("s3_final_B", 32'(B), 32'hA);
    check("s3_final_bits", 32'(bits), 4);
    pulse_reset();
    fire("s4_start", 5, 10);
    fire("s4_1023", 1023, 10);
    fire("s4_1024", 1024, 10);
    check("s4_thresh_B", 32'(B), 32'h1);
    for (int i = 0; i < 40; i++) fire("s4_short", 20, 5);
    check("s4_sat_bits", 32'(bits), 31);
    check("s4_sat_B", 32'(B), 0);
    fire("s4_edge_at_to", TIMEOUT, 10);
    check("s4_edge_wins_B", 32'(B), 32'h1);
    at_cyc(le + OFF + 50);
    check("s4_frame_cont", 32'(cnt), 50);
    fire("s5_hold_start", TIMEOUT + 1, 3000);
    at_cyc(le + OFF + 3000);
    check("s5_hold_cnt", 32'(cnt), 3000);
    check("s5_hold_bits", 32'(bits), 0);
    fire("s5_next", 3100, 10);
    at_cyc(le + OFF + 200);
    check("s6_pre_rst_cnt", 32'(cnt), 200);
    #2;
    rst = 1'b0;
    m_act = 1'b0;
    #1;
    check("s6_async_cnt", 32'(cnt), 0);
    check("s6_async_B", 32'(B), 0);
    check("s6_async_bits", 32'(bits), 0);
    @(negedge clk);
    rst = 1'b1;
    le = cyc;
    fire("s6_start", 3, 10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
